// File: rtl/send_packet_arbiter_if.sv
// -----------------------------------------------------------------------------
// send_packet_arbiter_if
//
// Purpose: bundles the requester-side handshakes (HC and SOF), the frame
// counter control and the forwarded write bus towards the packet encoder.
// The clock and reset stay as plain ports on the modules.
//
// Signals:
//   hc_req, hc_wen, hc_pid[3:0], hc_addr[6:0], hc_endp[3:0]   HC requester
//   hc_gnt                                                     grant to HC
//   sof_req, sof_wen                                           SOF requester
//   sof_gnt                                                    grant to SOF
//   frame_clr                                                  clear frame counter
//   frame_num[10:0]                                            current frame number
//   tx_wen, tx_pid[3:0], tx_addr[6:0], tx_endp[3:0],
//   tx_frame[10:0]                                             write to the engine
//   proto_err                                                  write without grant
//
// Modports:
//   master  the requesters / encoder environment around the arbiter
//   slave   the arbiter itself
// -----------------------------------------------------------------------------
interface send_packet_arbiter_if;
   logic        hc_req;
   logic        hc_wen;
   logic [3:0]  hc_pid;
   logic [6:0]  hc_addr;
   logic [3:0]  hc_endp;
   logic        hc_gnt;

   logic        sof_req;
   logic        sof_wen;
   logic        sof_gnt;

   logic        frame_clr;
   logic [10:0] frame_num;

   logic        tx_wen;
   logic [3:0]  tx_pid;
   logic [6:0]  tx_addr;
   logic [3:0]  tx_endp;
   logic [10:0] tx_frame;

   logic        proto_err;

   modport master (
      output hc_req, hc_wen, hc_pid, hc_addr, hc_endp,
      input  hc_gnt,
      output sof_req, sof_wen,
      input  sof_gnt,
      output frame_clr,
      input  frame_num,
      input  tx_wen, tx_pid, tx_addr, tx_endp, tx_frame,
      input  proto_err
   );

   modport slave (
      input  hc_req, hc_wen, hc_pid, hc_addr, hc_endp,
      output hc_gnt,
      input  sof_req, sof_wen,
      output sof_gnt,
      input  frame_clr,
      output frame_num,
      output tx_wen, tx_pid, tx_addr, tx_endp, tx_frame,
      output proto_err
   );
endinterface

// File: rtl/send_packet_arbiter.sv
// -----------------------------------------------------------------------------
// send_packet_arbiter
//
// Purpose: shares the single USB host send-packet engine between the host
// transaction generator (HC) and the SOF transmitter (SOF). SOF has priority
// when both request from IDLE, but an active grant is never preempted; the
// owner keeps the engine until it drops its request, after which the engine
// idles for GAP_CYCLES cycles. Granted writes are forwarded through one
// register stage. The block also owns the 11-bit USB frame counter and
// inserts SOF_PID / frame number into SOF packets.
//
// Parameters:
//   SOF_PID     PID placed on tx_pid for SOF packets
//   GAP_CYCLES  idle cycles forced after every release (>= 1)
//
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset (clears control and datapath)
//   bus   send_packet_arbiter_if.slave: requester handshakes, frame counter
//         control/status and the forwarded write bus
// -----------------------------------------------------------------------------
module send_packet_arbiter #(
   parameter logic [3:0] SOF_PID    = 4'h5,
   parameter int         GAP_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   send_packet_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_HC  = 2'd1,
      GNT_SOF = 2'd2,
      GAP     = 2'd3
   } state_t;

   // The gap counter needs to reach GAP_CYCLES-1; keep it at least one bit.
   localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   state_t        state;
   state_t        state_nxt;
   logic [GW-1:0] gap_cnt;

   logic          hc_owns;
   logic          sof_owns;

   logic          fwd_hc_p0;
   logic          fwd_sof_p0;
   logic          err_p0;

   logic          tx_wen_p1;
   logic [3:0]    tx_pid_p1;
   logic [6:0]    tx_addr_p1;
   logic [3:0]    tx_endp_p1;
   logic [10:0]   tx_frame_p1;
   logic          err_p1;
   logic [10:0]   frame_p1;

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Gap length counter; it only runs while in GAP and restarts on every entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         gap_cnt <= '0;
      end else if (state != GAP) begin
         gap_cnt <= '0;
      end else if (gap_cnt != GAP_LAST) begin
         gap_cnt <= gap_cnt + GW'(1);
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            // SOF wins a tie; requests are only arbitrated from IDLE.
            if (bus.sof_req) begin
               state_nxt = GNT_SOF;
            end else if (bus.hc_req) begin
               state_nxt = GNT_HC;
            end
         end
         GNT_HC: begin
            if (!bus.hc_req) begin
               state_nxt = GAP;
            end
         end
         GNT_SOF: begin
            if (!bus.sof_req) begin
               state_nxt = GAP;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: output decode (grants come straight from the state register, so the
   // two grants are mutually exclusive and glitch-free)
   // --------------------------------------------------------------------------
   always_comb begin
      hc_owns  = 1'b0;
      sof_owns = 1'b0;
      unique case (state)
         GNT_HC:  hc_owns  = 1'b1;
         GNT_SOF: sof_owns = 1'b1;
         default: begin
            hc_owns  = 1'b0;
            sof_owns = 1'b0;
         end
      endcase
   end

   assign bus.hc_gnt  = hc_owns;
   assign bus.sof_gnt = sof_owns;

   // --------------------------------------------------------------------------
   // Stage p0: qualify write strobes against the current owner
   // --------------------------------------------------------------------------
   always_comb begin
      fwd_hc_p0  = bus.hc_wen  & hc_owns;
      fwd_sof_p0 = bus.sof_wen & sof_owns;
      // Any strobe from a requester that does not own the engine, which
      // includes every strobe seen in IDLE or GAP.
      err_p0     = (bus.hc_wen & ~hc_owns) | (bus.sof_wen & ~sof_owns);
   end

   // --------------------------------------------------------------------------
   // Stage p1: registered write multiplexer and frame counter
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wen_p1 <= 1'b0;
         err_p1    <= 1'b0;
      end else begin
         tx_wen_p1 <= fwd_hc_p0 | fwd_sof_p0;
         err_p1    <= err_p0;
      end
   end

   // Write fields hold their last value between forwarded writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_pid_p1   <= '0;
         tx_addr_p1  <= '0;
         tx_endp_p1  <= '0;
         tx_frame_p1 <= '0;
      end else if (fwd_hc_p0) begin
         tx_pid_p1   <= bus.hc_pid;
         tx_addr_p1  <= bus.hc_addr;
         tx_endp_p1  <= bus.hc_endp;
         tx_frame_p1 <= frame_p1;
      end else if (fwd_sof_p0) begin
         tx_pid_p1   <= SOF_PID;
         tx_addr_p1  <= '0;
         tx_endp_p1  <= '0;
         tx_frame_p1 <= frame_p1;
      end
   end

   // The SOF packet carries the pre-increment frame number; a clear wins over
   // a simultaneous increment. The 11-bit add wraps 7FF -> 000 naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_p1 <= '0;
      end else if (bus.frame_clr) begin
         frame_p1 <= '0;
      end else if (fwd_sof_p0) begin
         frame_p1 <= frame_p1 + 11'd1;
      end
   end

   assign bus.tx_wen    = tx_wen_p1;
   assign bus.tx_pid    = tx_pid_p1;
   assign bus.tx_addr   = tx_addr_p1;
   assign bus.tx_endp   = tx_endp_p1;
   assign bus.tx_frame  = tx_frame_p1;
   assign bus.proto_err = err_p1;
   assign bus.frame_num = frame_p1;

endmodule

// File: tb/tb_send_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_send_packet_arbiter
//
// Directed bench for send_packet_arbiter. Expected forwarded writes are pushed
// to a queue when the stimulus is driven and popped whenever the DUT raises
// tx_wen. Inputs change 1 time unit after the rising edge; outputs are
// sampled at that same point.
// -----------------------------------------------------------------------------
module tb_send_packet_arbiter;

   localparam logic [3:0] SOF_PID = 4'h5;

   logic clk;
   logic rst;

   send_packet_arbiter_if bus ();

   send_packet_arbiter #(
      .SOF_PID    (SOF_PID),
      .GAP_CYCLES (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp;
   int          n_err;
   logic [25:0] exp_q[$];
   logic [10:0] exp_frame;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and score any forwarded write against the queue.
   task automatic step();
      logic [25:0] exp_w;
      @(posedge clk);
      #1;
      if (bus.tx_wen !== 1'b0) begin
         if (exp_q.size() == 0) begin
            chk("tx_wen_unexpected", 32'(bus.tx_wen), 32'd0);
         end else begin
            exp_w = exp_q.pop_front();
            chk("tx_word", 32'({bus.tx_pid, bus.tx_addr, bus.tx_endp, bus.tx_frame}), 32'(exp_w));
         end
      end
   endtask

   task automatic push_hc(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
      exp_q.push_back({pid, addr, endp, exp_frame});
   endtask

   task automatic push_sof();
      exp_q.push_back({SOF_PID, 7'h00, 4'h0, exp_frame});
      exp_frame = exp_frame + 11'd1;
   endtask

   // Hold sof_wen for n cycles while SOF owns the engine.
   task automatic sof_burst(input int n);
      bus.sof_wen = 1'b1;
      for (int i = 0; i < n; i++) begin
         push_sof();
         step();
      end
      bus.sof_wen = 1'b0;
      step();
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      exp_frame = 11'h000;

      rst           = 1'b1;
      bus.hc_req    = 1'b0;
      bus.hc_wen    = 1'b0;
      bus.hc_pid    = 4'h0;
      bus.hc_addr   = 7'h00;
      bus.hc_endp   = 4'h0;
      bus.sof_req   = 1'b0;
      bus.sof_wen   = 1'b0;
      bus.frame_clr = 1'b0;

      // Reset state
      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_hc_gnt",    32'(bus.hc_gnt),    32'd0);
      chk("rst_sof_gnt",   32'(bus.sof_gnt),   32'd0);
      chk("rst_tx_wen",    32'(bus.tx_wen),    32'd0);
      chk("rst_proto_err", 32'(bus.proto_err), 32'd0);
      chk("rst_frame_num", 32'(bus.frame_num), 32'd0);
      chk("rst_tx_fields", 32'({bus.tx_pid, bus.tx_addr, bus.tx_endp, bus.tx_frame}), 32'd0);

      // HC grant and one forwarded write
      bus.hc_req = 1'b1;
      step();
      chk("hc_gnt_after_req", 32'(bus.hc_gnt), 32'd1);
      chk("sof_gnt_idle_hc",  32'(bus.sof_gnt), 32'd0);
      bus.hc_wen  = 1'b1;
      bus.hc_pid  = 4'h1;
      bus.hc_addr = 7'h12;
      bus.hc_endp = 4'h3;
      push_hc(4'h1, 7'h12, 4'h3);
      step();
      chk("hc_tx_wen", 32'(bus.tx_wen), 32'd1);
      bus.hc_wen = 1'b0;
      step();
      chk("hc_tx_wen_one_pulse", 32'(bus.tx_wen), 32'd0);
      chk("hc_frame_unchanged",  32'(bus.frame_num), 32'd0);
      chk("hc_tx_hold", 32'({bus.tx_pid, bus.tx_addr, bus.tx_endp}), 32'({4'h1, 7'h12, 4'h3}));
      chk("hc_q_drained", 32'(exp_q.size()), 32'd0);

      // Write on the same edge as the request drop is still forwarded
      bus.hc_req  = 1'b0;
      bus.hc_wen  = 1'b1;
      bus.hc_pid  = 4'h9;
      bus.hc_addr = 7'h55;
      bus.hc_endp = 4'hA;
      push_hc(4'h9, 7'h55, 4'hA);
      step();
      bus.hc_wen = 1'b0;
      chk("drop_edge_hc_gnt", 32'(bus.hc_gnt), 32'd0);
      chk("drop_edge_q", 32'(exp_q.size()), 32'd0);
      step();   // back in IDLE

      // Simultaneous requests: SOF wins, HC waits through GAP
      bus.hc_req  = 1'b1;
      bus.sof_req = 1'b1;
      step();
      chk("tie_sof_gnt", 32'(bus.sof_gnt), 32'd1);
      chk("tie_hc_gnt",  32'(bus.hc_gnt),  32'd0);
      bus.sof_req = 1'b0;
      step();
      chk("gap_grants", 32'({bus.hc_gnt, bus.sof_gnt}), 32'd0);
      step();
      chk("idle_grants", 32'({bus.hc_gnt, bus.sof_gnt}), 32'd0);
      step();
      chk("hc_after_gap", 32'({bus.hc_gnt, bus.sof_gnt}), 32'b10);

      // SOF raised while HC owns the engine does not preempt
      bus.sof_req = 1'b1;
      step();
      chk("no_preempt", 32'({bus.hc_gnt, bus.sof_gnt}), 32'b10);
      bus.hc_req = 1'b0;
      step();
      step();
      step();
      chk("sof_after_hc", 32'({bus.hc_gnt, bus.sof_gnt}), 32'b01);

      // Count the frame up to 7FF, then wrap on one more SOF write
      sof_burst(2047);
      chk("frame_7ff", 32'(bus.frame_num), 32'h7FF);
      sof_burst(1);
      chk("frame_wrap", 32'(bus.frame_num), 32'h000);
      chk("wrap_tx_frame", 32'(bus.tx_frame), 32'h7FF);
      chk("wrap_tx_pid", 32'(bus.tx_pid), 32'(SOF_PID));

      // frame_clr together with a granted SOF write at 123
      sof_burst(291);
      chk("frame_123", 32'(bus.frame_num), 32'h123);
      bus.sof_wen   = 1'b1;
      bus.frame_clr = 1'b1;
      push_sof();
      exp_frame = 11'h000;
      step();
      bus.sof_wen   = 1'b0;
      bus.frame_clr = 1'b0;
      chk("clr_frame_num", 32'(bus.frame_num), 32'h000);
      chk("clr_tx_frame",  32'(bus.tx_frame),  32'h123);
      chk("clr_q", 32'(exp_q.size()), 32'd0);

      // Strobe from the non-owner while HC is granted
      bus.sof_req = 1'b0;
      step();
      step();
      bus.hc_req = 1'b1;
      step();
      chk("hc_regrant", 32'(bus.hc_gnt), 32'd1);
      bus.sof_wen = 1'b1;
      step();
      bus.sof_wen = 1'b0;
      chk("err_no_tx_wen", 32'(bus.tx_wen), 32'd0);
      chk("err_pulse", 32'(bus.proto_err), 32'd1);
      chk("err_frame", 32'(bus.frame_num), 32'h000);
      chk("err_tx_hold", 32'(bus.tx_frame), 32'h123);
      step();
      chk("err_one_cycle", 32'(bus.proto_err), 32'd0);

      // Strobe in GAP is not forwarded
      bus.hc_req = 1'b0;
      step();
      bus.hc_wen = 1'b1;
      step();
      bus.hc_wen = 1'b0;
      chk("gap_wen_err", 32'({bus.tx_wen, bus.proto_err}), 32'b01);

      // Reset during GNT_SOF with a write in flight
      bus.sof_req = 1'b1;
      step();
      chk("sof_grant_pre_rst", 32'(bus.sof_gnt), 32'd1);
      sof_burst(1);
      bus.sof_wen = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.sof_wen = 1'b0;
      exp_frame = 11'h000;
      chk("rst_mid_grants", 32'({bus.hc_gnt, bus.sof_gnt}), 32'd0);
      chk("rst_mid_ctrl", 32'({bus.tx_wen, bus.proto_err}), 32'd0);
      chk("rst_mid_fields", 32'({bus.tx_pid, bus.tx_addr, bus.tx_endp, bus.tx_frame}), 32'd0);
      chk("rst_mid_frame", 32'(bus.frame_num), 32'd0);
      step();
      chk("rst_regrant", 32'(bus.sof_gnt), 32'd1);
      chk("rst_no_late_wen", 32'(bus.tx_wen), 32'd0);
      sof_burst(1);
      chk("rst_post_frame", 32'(bus.frame_num), 32'h001);
      bus.sof_req = 1'b0;
      step();
      step();

      chk("final_q_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
